sobel_frame_controller: RTL and testbench

- Frame-level sequencer in front of the Sobel 3x3 window buffer (double-line FIFO plus window modulator).
- Arms the buffer per frame, gates grayscale pixels into it, and tracks input raster position.
- Counts window-done events coming back from the buffer and tags each valid window with its centre coordinate.
- Signals frame completion, and flags protocol errors (surplus pixels or windows, drain timeout).

---
 rtl/sobel_frame_controller.sv | 213 +++++++++++++++++++++
 tb/tb_sobel_frame_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_controller.sv
// Frame sequencer ahead of the Sobel 3x3 window buffer: arms the buffer,
// gates pixels into it, tags returned windows with centre coords.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   start_i          begin a frame (IDLE only)
//   pix_valid_i/pix_i  upstream grayscale pixel stream
//   buf_clr_o        one-cycle buffer clear
//   buf_we_o/buf_data_o  registered pixel write to the buffer
//   win_done_i       window-ready strobe from the buffer
//   win_valid_o      window fully inside the image (1-cycle pulse)
//   win_x_o/win_y_o  window centre column/row
//   busy_o           frame in progress
//   frame_done_o     end-of-frame pulse
//   err_o            sticky protocol error, cleared on accepted start
module sobel_frame_controller #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CW       = 10,
  parameter int RW       = 9,
  parameter int DRAIN_TO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          pix_valid_i,
  input  logic [7:0]    pix_i,
  output logic          buf_clr_o,
  output logic          buf_we_o,
  output logic [7:0]    buf_data_o,
  input  logic          win_done_i,
  output logic          win_valid_o,
  output logic [CW-1:0] win_x_o,
  output logic [RW-1:0] win_y_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          err_o
);

  localparam int DW = $clog2(DRAIN_TO + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  // Window events begin on row 2, so the event row index is
  // the bottom row minus 2; its last value is IMG_H-3.
  localparam logic [RW-1:0] EV_LAST  = RW'(IMG_H - 3);
  localparam logic [DW-1:0] TO_LAST  = DW'(DRAIN_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] ev_row_q, ev_row_d;
  logic [DW-1:0] drain_q, drain_d;

  logic          we_q, we_d;
  logic [7:0]    data_q, data_d;
  logic          wv_q, wv_d;
  logic [CW-1:0] wx_q, wx_d;
  logic [RW-1:0] wy_q, wy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic pix_ok;
  logic win_ok;
  logic last_pix;
  logic last_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      ev_row_q  <= '0;
      drain_q   <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
      wv_q      <= 1'b0;
      wx_q      <= '0;
      wy_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      ev_row_q  <= ev_row_d;
      drain_q   <= drain_d;
      we_q      <= we_d;
      data_q    <= data_d;
      wv_q      <= wv_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    out_col_d = out_col_q;
    ev_row_d  = ev_row_q;
    drain_d   = drain_q;
    we_d      = 1'b0;
    data_d    = data_q;
    wv_d      = 1'b0;
    wx_d      = wx_q;
    wy_d      = wy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    pix_ok   = pix_valid_i && (state_q == STREAM);
    win_ok   = win_done_i &&
               ((state_q == STREAM) || (state_q == DRAIN));
    last_pix = (in_row_q == ROW_LAST) &&
               (in_col_q == COL_LAST);
    last_win = (ev_row_q == EV_LAST) &&
               (out_col_q == COL_LAST);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          err_d   = 1'b0;
        end
      end
      CLEAR: begin
        in_col_d  = '0;
        in_row_d  = '0;
        out_col_d = '0;
        ev_row_d  = '0;
        drain_d   = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (pix_ok && last_pix) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (win_ok && last_win) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (drain_q == TO_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
    endcase

    if (pix_ok) begin
      we_d   = 1'b1;
      data_d = pix_i;
      if (in_col_q == COL_LAST) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_LAST) ?
                   '0 : in_row_q + RW'(1);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end

    if (win_ok) begin
      // Centre is only computed for interior windows, so
      // out_col-1 never underflows.
      if (out_col_q >= CW'(2)) begin
        wv_d = 1'b1;
        wx_d = out_col_q - CW'(1);
        wy_d = ev_row_q + RW'(1);
      end
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        ev_row_d  = (ev_row_q == EV_LAST) ?
                    '0 : ev_row_q + RW'(1);
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end

    if (pix_valid_i && (state_q != STREAM))
      err_d = 1'b1;
    if (win_done_i &&
        ((state_q == IDLE) || (state_q == CLEAR)))
      err_d = 1'b1;
  end

  assign buf_clr_o    = (state_q == CLEAR);
  assign busy_o       = (state_q != IDLE);
  assign buf_we_o     = we_q;
  assign buf_data_o   = data_q;
  assign win_valid_o  = wv_q;
  assign win_x_o      = wx_q;
  assign win_y_o      = wy_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_sobel_frame_controller.sv
// Self-checking bench for sobel_frame_controller on an 8x4 image.
// The bench also plays the window buffer (one event per row>=2 write).
module tb_sobel_frame_controller;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int CW   = 3;
  localparam int RW   = 2;
  localparam int DTO  = 16;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          pix_valid_i;
  logic [7:0]    pix_i;
  logic          buf_clr_o;
  logic          buf_we_o;
  logic [7:0]    buf_data_o;
  logic          win_done_i;
  logic          win_valid_o;
  logic [CW-1:0] win_x_o;
  logic [RW-1:0] win_y_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          err_o;

  sobel_frame_controller #(
    .IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW),
    .DRAIN_TO(DTO)
  ) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i),
    .pix_valid_i(pix_valid_i), .pix_i(pix_i),
    .buf_clr_o(buf_clr_o),
    .buf_we_o(buf_we_o), .buf_data_o(buf_data_o),
    .win_done_i(win_done_i),
    .win_valid_o(win_valid_o),
    .win_x_o(win_x_o), .win_y_o(win_y_o),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int cyc;
  int we_cnt, wv_cnt, done_cnt, clr_cnt;
  int exp_wv, win_limit;
  int last_we_cyc, done_cyc;
  int first_x, first_y, last_x, last_y;
  logic [7:0] exp_pix[$];
  int exp_x[$];
  int exp_y[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    we_cnt = 0; wv_cnt = 0; done_cnt = 0; clr_cnt = 0;
    exp_wv = 0; last_we_cyc = -1; done_cyc = -1;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    exp_pix.delete(); exp_x.delete(); exp_y.delete();
  endtask

  // One clock, then sample and score everything the DUT shows.
  task automatic tick();
    int w, c, r, ex, ey;
    @(posedge clk);
    #1;
    cyc++;
    win_done_i = 1'b0;
    if (buf_we_o) begin
      w = we_cnt;
      we_cnt++;
      checks++;
      assert (exp_pix.size() > 0) else begin
        errors++;
        $error("FAIL we_extra observed=%0d expected=0",
               we_cnt);
      end
      if (exp_pix.size() > 0)
        chk("buf_data", 32'(buf_data_o),
            32'(exp_pix.pop_front()));
      if (w == NPIX - 1) last_we_cyc = cyc;
      if (w >= 2 * W && w < 2 * W + win_limit) begin
        win_done_i = 1'b1;
        c = w % W;
        r = w / W;
        if (c >= 2) begin
          exp_x.push_back(c - 1);
          exp_y.push_back(r - 1);
          exp_wv++;
        end
      end
    end
    if (win_valid_o) begin
      wv_cnt++;
      if (first_x < 0) begin
        first_x = int'(win_x_o);
        first_y = int'(win_y_o);
      end
      last_x = int'(win_x_o);
      last_y = int'(win_y_o);
      checks++;
      assert (exp_x.size() > 0) else begin
        errors++;
        $error("FAIL win_extra observed=%0d expected=%0d",
               wv_cnt, exp_wv);
      end
      if (exp_x.size() > 0) begin
        ex = exp_x.pop_front();
        ey = exp_y.pop_front();
        chk("win_x", 32'(win_x_o), 32'(ex));
        chk("win_y", 32'(win_y_o), 32'(ey));
      end
    end
    if (frame_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (buf_clr_o) clr_cnt++;
  endtask

  task automatic run_frame(input int duty,
                           input bit seq,
                           input int lim,
                           input bit overrun,
                           input int abort_at,
                           input int exp_err,
                           input int exp_dly,
                           input int exp_nwv);
    int sent, guard;
    sb_reset();
    win_limit = lim;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("clr_pulse", 32'(buf_clr_o), 32'(1));
    chk("start_busy", 32'(busy_o), 32'(1));
    chk("start_err_clr", 32'(err_o), 32'(0));
    tick();
    chk("clr_one_cycle", 32'(buf_clr_o), 32'(0));
    sent = 0;
    guard = 0;
    while (sent < NPIX && guard < 1000) begin
      pix_valid_i = ($urandom_range(0, 99) < duty);
      if (pix_valid_i) begin
        pix_i = seq ? 8'(sent) : 8'($urandom);
        exp_pix.push_back(pix_i);
        sent++;
      end
      tick();
      guard++;
      if (abort_at > 0 && sent == abort_at) begin
        pix_valid_i = 1'b0;
        return;
      end
    end
    pix_valid_i = 1'b0;
    chk("pix_budget", 32'(sent), 32'(NPIX));
    if (overrun) begin
      pix_valid_i = 1'b1;
      pix_i = 8'hA5;
      tick();
      pix_valid_i = 1'b0;
      chk("overrun_err", 32'(err_o), 32'(1));
    end
    guard = 0;
    while (done_cnt == 0 && guard < 100) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("done_count", 32'(done_cnt), 32'(1));
    chk("done_delay", 32'(done_cyc - last_we_cyc),
        32'(exp_dly));
    chk("we_count", 32'(we_cnt), 32'(NPIX));
    chk("clr_count", 32'(clr_cnt), 32'(1));
    chk("wv_count", 32'(wv_cnt), 32'(exp_wv));
    chk("wv_total", 32'(wv_cnt), 32'(exp_nwv));
    chk("end_err", 32'(err_o), 32'(exp_err));
    chk("end_busy", 32'(busy_o), 32'(0));
  endtask

  initial begin
    cyc = 0;
    win_limit = 0;
    sb_reset();
    rst = 1'b0;
    start_i = 1'b1;
    pix_valid_i = 1'b1;
    pix_i = 8'h3C;
    win_done_i = 1'b0;
    repeat (3) tick();
    chk("rst_outs",
        32'({buf_clr_o, buf_we_o, buf_data_o,
             win_valid_o, win_x_o, win_y_o,
             busy_o, frame_done_o, err_o}), 32'(0));
    start_i = 1'b0;
    pix_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_o), 32'(0));
    chk("idle_err", 32'(err_o), 32'(0));

    win_done_i = 1'b1;
    tick();
    chk("idle_win_err", 32'(err_o), 32'(1));

    run_frame(100, 1'b1, 2 * W, 1'b0, 0, 0, 1, 12);
    chk("nom_first_x", 32'(first_x), 32'(1));
    chk("nom_first_y", 32'(first_y), 32'(1));
    chk("nom_last_x", 32'(last_x), 32'(6));
    chk("nom_last_y", 32'(last_y), 32'(2));

    run_frame(50, 1'b0, 2 * W, 1'b0, 0, 0, 1, 12);

    run_frame(100, 1'b1, 2 * W, 1'b1, 0, 1, 1, 12);
    repeat (4) tick();
    chk("err_sticky", 32'(err_o), 32'(1));

    run_frame(70, 1'b0, 2 * W - 4, 1'b0, 0, 1, DTO, 8);

    run_frame(100, 1'b1, 2 * W, 1'b0, 10, 0, 1, 12);
    rst = 1'b0;
    repeat (2) tick();
    chk("abort_outs",
        32'({buf_we_o, win_valid_o, busy_o,
             frame_done_o, err_o}), 32'(0));
    rst = 1'b1;
    repeat (5) tick();
    chk("stale_done", 32'(done_cnt), 32'(0));
    run_frame(100, 1'b1, 2 * W, 1'b0, 0, 0, 1, 12);
    chk("post_first_x", 32'(first_x), 32'(1));
    chk("post_first_y", 32'(first_y), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
